// File: rtl/hemaia_reset_pkg.sv
// Shared types and helpers for the per-domain reset requester.
package hemaia_reset_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_REL = 2'd2,
        DONE     = 2'd3
    } state_e;

    // Bits needed to hold counts 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/hemaia_reset_ack_sync.sv
// Multi-stage flop synchroniser for the acknowledge vector; clears to 0 on reset.
module hemaia_reset_ack_sync #(
    parameter int unsigned Width  = 1,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             sync_ff_rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk_i or negedge sync_ff_rst) begin
        if (!sync_ff_rst) begin
            for (int unsigned i = 0; i < Stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[Stages-1];

endmodule

// File: rtl/hemaia_reset_requester.sv
// Initiator side of the per-domain reset handshake: drives flop-sourced local
// reset requests, waits for the synchronised acks, reports done or timeout.
module hemaia_reset_requester
    import hemaia_reset_pkg::*;
#(
    parameter int unsigned NumReset        = 4,
    parameter int unsigned MinAssertCycles = 16,
    parameter int unsigned AckTimeout      = 1024,
    parameter int unsigned AckSyncStages   = 2
) (
    input  logic                clk_i,
    input  logic                sync_ff_rst,
    input  logic                req_valid_i,
    input  logic [NumReset-1:0] req_mask_i,
    output logic                req_ready_o,
    output logic [NumReset-1:0] async_local_rst_no,
    input  logic [NumReset-1:0] rst_ack_ni,
    output logic                busy_o,
    output logic                done_o,
    output logic                timeout_o,
    output logic [NumReset-1:0] timeout_mask_o
);

    localparam int unsigned    CntW     = cnt_width(AckTimeout);
    localparam logic [CntW-1:0] HoldLast = CntW'(MinAssertCycles - 1);
    localparam logic [CntW-1:0] ToLast   = CntW'(AckTimeout - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == '1) ? v : v + CntOne;
    endfunction

    state_e              state_q, state_d;
    logic [NumReset-1:0] mask_q, mask_d;
    logic [CntW-1:0]     hold_q, hold_d;
    logic [CntW-1:0]     to_q, to_d;
    logic [NumReset-1:0] rst_q, rst_d;
    logic                tmo_q, tmo_d;
    logic [NumReset-1:0] tmask_q, tmask_d;
    logic                ready_q, busy_q, done_q;
    logic [NumReset-1:0] ack_s;
    logic [NumReset-1:0] sel_ack;
    logic                accept;

    hemaia_reset_ack_sync #(
        .Width  (NumReset),
        .Stages (AckSyncStages)
    ) u_ack_sync (
        .clk_i       (clk_i),
        .sync_ff_rst (sync_ff_rst),
        .d           (rst_ack_ni),
        .q           (ack_s)
    );

    assign sel_ack = ack_s & mask_q;
    assign accept  = req_valid_i & ready_q;

    // Next-state and next-output logic; success is checked before timeout.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        hold_d  = hold_q;
        to_d    = to_q;
        rst_d   = rst_q;
        tmo_d   = tmo_q;
        tmask_d = tmask_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mask_d  = req_mask_i;
                    hold_d  = '0;
                    to_d    = '0;
                    tmo_d   = 1'b0;
                    tmask_d = '0;
                    if (req_mask_i != '0) begin
                        state_d = ASSERT;
                        rst_d   = ~req_mask_i;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ASSERT: begin
                hold_d = sat_inc(hold_q);
                to_d   = sat_inc(to_q);
                if ((hold_q >= HoldLast) && (sel_ack == '0)) begin
                    state_d = WAIT_REL;
                    rst_d   = '1;
                    to_d    = '0;
                end else if (to_q == ToLast) begin
                    state_d = DONE;
                    rst_d   = '1;
                    tmo_d   = 1'b1;
                    tmask_d = sel_ack;
                end
            end
            WAIT_REL: begin
                to_d = sat_inc(to_q);
                if (sel_ack == mask_q) begin
                    state_d = DONE;
                end else if (to_q == ToLast) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                    tmask_d = ~ack_s & mask_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rst_d   = '1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge sync_ff_rst) begin
        if (!sync_ff_rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            hold_q  <= '0;
            to_q    <= '0;
            rst_q   <= '1;
            tmo_q   <= 1'b0;
            tmask_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            rst_q   <= rst_d;
            tmo_q   <= tmo_d;
            tmask_q <= tmask_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign async_local_rst_no = rst_q;
    assign req_ready_o        = ready_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign timeout_o          = tmo_q;
    assign timeout_mask_o     = tmask_q;

endmodule

// File: tb/tb_hemaia_reset_requester.sv
// Scoreboard bench for hemaia_reset_requester with a behavioural ack-domain model.
module tb_hemaia_reset_requester;

    localparam int unsigned NR  = 4;
    localparam int unsigned MIN = 16;
    localparam int unsigned ATO = 64;
    localparam int unsigned STG = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [NR-1:0] req_mask;
    logic          req_ready;
    logic [NR-1:0] local_rst_n;
    logic [NR-1:0] ack_n;
    logic          busy, done, tmo;
    logic [NR-1:0] tmask;

    hemaia_reset_requester #(
        .NumReset        (NR),
        .MinAssertCycles (MIN),
        .AckTimeout      (ATO),
        .AckSyncStages   (STG)
    ) dut (
        .clk_i              (clk),
        .sync_ff_rst        (rst_n),
        .req_valid_i        (req_valid),
        .req_mask_i         (req_mask),
        .req_ready_o        (req_ready),
        .async_local_rst_no (local_rst_n),
        .rst_ack_ni         (ack_n),
        .busy_o             (busy),
        .done_o             (done),
        .timeout_o          (tmo),
        .timeout_mask_o     (tmask)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] mask;
        int            lo_cycles;
        logic          to;
        logic [NR-1:0] tmask;
        int            busy_cycles;   // -1: not predicted
    } exp_t;

    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    // Domain behaviour per channel: 0 follows request after dly, 1 never enters
    // reset, 2 never leaves reset once entered, 3 random noise (unselected only).
    int         mode [NR];
    int         dly  [NR];
    logic [7:0] hist [NR];
    logic       latched [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one request from the domain behaviours alone.
    function automatic exp_t model(input logic [NR-1:0] m);
        exp_t          e;
        logic [NR-1:0] never_in  = '0;
        logic [NR-1:0] never_out = '0;
        for (int i = 0; i < NR; i++) begin
            if (m[i] && mode[i] == 1) never_in[i] = 1'b1;
            if (m[i] && mode[i] == 2) never_out[i] = 1'b1;
        end
        e.mask = m;
        if (m == '0) begin
            e.lo_cycles = 0; e.to = 1'b0; e.tmask = '0; e.busy_cycles = 1;
        end else if (never_in != '0) begin
            e.lo_cycles = ATO; e.to = 1'b1; e.tmask = never_in; e.busy_cycles = ATO + 1;
        end else if (never_out != '0) begin
            e.lo_cycles = MIN; e.to = 1'b1; e.tmask = never_out; e.busy_cycles = MIN + ATO + 1;
        end else begin
            e.lo_cycles = MIN; e.to = 1'b0; e.tmask = '0; e.busy_cycles = -1;
        end
        return e;
    endfunction

    // Ack-domain model
    initial begin
        for (int i = 0; i < NR; i++) begin
            hist[i] = 8'hFF; latched[i] = 1'b0; mode[i] = 0; dly[i] = 0;
        end
        ack_n = '1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                logic base;
                hist[i] = {hist[i][6:0], local_rst_n[i]};
                base = hist[i][dly[i]];
                case (mode[i])
                    1: ack_n[i] = 1'b1;
                    2: begin
                        if (!busy) latched[i] = 1'b0;
                        else if (!base) latched[i] = 1'b1;
                        ack_n[i] = latched[i] ? 1'b0 : base;
                    end
                    3: ack_n[i] = 1'($urandom);
                    default: ack_n[i] = base;
                endcase
            end
        end
    end

    // Monitor: accumulates each transaction, compares against the scoreboard on done
    initial begin
        int            lo_c, busy_c;
        logic [NR-1:0] lo_or, lo_and;
        exp_t          e;
        lo_c = 0; busy_c = 0; lo_or = '0; lo_and = '1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lo_c = 0; busy_c = 0; lo_or = '0; lo_and = '1;
            end else begin
                check("ready_vs_busy", 32'(req_ready), 32'(!busy));
                if (local_rst_n != '1) begin
                    lo_c++;
                    lo_or  |= ~local_rst_n;
                    lo_and &= ~local_rst_n;
                end
                if (busy) busy_c++;
                if (done) begin
                    if (sb.size() == 0) begin
                        ntests++; nfail++;
                        $display("FAIL done_unexpected: got done with empty scoreboard expected none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("lo_cycles", 32'(lo_c), 32'(e.lo_cycles));
                        check("lo_bits_any", 32'(lo_or), 32'(e.mask));
                        check("lo_bits_all", (lo_c != 0) ? 32'(lo_and) : 32'(0), 32'(e.mask));
                        check("timeout", 32'(tmo), 32'(e.to));
                        check("timeout_mask", 32'(tmask), 32'(e.tmask));
                        if (e.busy_cycles >= 0) check("busy_cycles", 32'(busy_c), 32'(e.busy_cycles));
                    end
                    lo_c = 0; busy_c = 0; lo_or = '0; lo_and = '1;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(req_ready && !busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            ntests++; nfail++;
            $display("FAIL idle_wait: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic cfg(input int m0, input int m1, input int m2, input int m3, input int d);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
        for (int i = 0; i < NR; i++) dly[i] = d;
    endtask

    // Called at a negedge with ready high; optionally keeps valid high with junk masks.
    task automatic issue(input logic [NR-1:0] m, input bit hold);
        int n = 0;
        req_valid = 1'b1;
        req_mask  = m;
        sb.push_back(model(m));
        @(negedge clk);
        if (hold) begin
            while (!done && n < 500) begin
                req_mask = NR'($urandom);
                @(negedge clk);
                n++;
            end
        end
        req_valid = 1'b0;
        req_mask  = NR'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_mask = '0;
        repeat (3) @(negedge clk);
        check("reset_local_rst", 32'(local_rst_n), 32'(4'hF));
        check("reset_ready", 32'(req_ready), 32'(1));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_timeout", 32'(tmo), 32'(0));
        check("reset_timeout_mask", 32'(tmask), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        wait_idle(); cfg(0, 0, 0, 0, 3); issue(4'b0101, 1'b0);
        wait_idle(); issue(4'b0000, 1'b0);
        wait_idle(); cfg(0, 0, 1, 0, 2); issue(4'b0100, 1'b0);
        wait_idle(); cfg(2, 0, 0, 0, 1); issue(4'b0001, 1'b0);
        wait_idle(); repeat (2) @(negedge clk); cfg(0, 0, 0, 0, 2); issue(4'b0011, 1'b0);
        wait_idle(); cfg(0, 3, 0, 0, 4); issue(4'b1101, 1'b1);

        // Asynchronous reset in the middle of ASSERT
        wait_idle(); cfg(0, 0, 0, 0, 2); issue(4'b0011, 1'b0);
        repeat (5) @(negedge clk);
        check("mid_assert_local_rst", 32'(local_rst_n), 32'(4'b1100));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_local_rst", 32'(local_rst_n), 32'(4'hF));
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_ready", 32'(req_ready), 32'(1));
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(); issue(4'b1000, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [NR-1:0] m;
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            m = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (m[i]) mode[i] = (r < 8) ? 1 : (r < 16) ? 2 : 0;
                else      mode[i] = (r < 50) ? 3 : 0;
                dly[i] = int'($urandom_range(0, 5));
            end
            issue(m, 1'($urandom));
        end

        wait_idle();
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/hemaia_reset_requester.md
Name: hemaia_reset_requester

Overview:
- Initiator side of the per-domain reset handshake.
- A software or host request selects a subset of reset channels. The block drives glitch-free, flop-sourced active-low local reset requests towards the per-domain reset synchronisers.
- It holds each request for a minimum time, then releases it and waits for the synchronised per-domain resets to acknowledge assertion and release.
- It reports completion or timeout. It sits in the always-on clock/reset domain next to the reset synchronisers.

Parameters:
- NumReset, 4, number of reset channels; 1..32.
- MinAssertCycles, 16, minimum clk_i cycles a local reset request is held low; >=1.
- AckTimeout, 1024, maximum clk_i cycles spent in ASSERT or WAIT_REL before aborting; must be > MinAssertCycles.
- AckSyncStages, 2, synchroniser depth on the acknowledge feedback; >=2.

Ports:
- clk_i, input, 1, always-on clock.
- sync_ff_rst, input, 1, asynchronous active-low reset.
- req_valid_i, input, 1, reset request valid.
- req_mask_i, input, NumReset, channels to reset; bit i selects channel i.
- req_ready_o, output, 1, high only in IDLE.
- async_local_rst_no, output, NumReset, active-low local reset requests, driven directly from flops.
- rst_ack_ni, input, NumReset, per-domain synchronised resets fed back; asynchronous to clk_i.
- busy_o, output, 1, high in any state other than IDLE.
- done_o, output, 1, single-cycle pulse when a request completes or aborts.
- timeout_o, output, 1, sticky abort flag; cleared on the next accepted request.
- timeout_mask_o, output, NumReset, channels whose acknowledge was missing at abort; sticky.

Behaviour:
- Interface: reset sync_ff_rst, asynchronous, active-low; clock clk_i.
- Reset values:
  - async_local_rst_no = all ones.
  - req_ready_o = 1.
  - busy_o = 0, done_o = 0, timeout_o = 0, timeout_mask_o = 0.
  - FSM in IDLE; counters 0; ack synchroniser flops 0.
- Ack path: rst_ack_ni passes through an AckSyncStages-deep flop synchroniser, giving ack_s. All decisions use ack_s only.
- Handshake: a request is accepted on a cycle with req_valid_i & req_ready_o. The mask is latched into mask_q. req_valid_i while busy is ignored; no queueing.
- FSM states:
  - IDLE
    - On accept with mask != 0: go to ASSERT. From cycle T+1, async_local_rst_no = ~mask_q; unselected bits stay 1. Clear timeout_o and timeout_mask_o.
    - On accept with mask == 0: go to DONE. No output toggles.
  - ASSERT
    - hold_cnt and to_cnt increment every cycle.
    - Exit to WAIT_REL when hold_cnt >= MinAssertCycles-1 and (ack_s & mask_q) == 0, i.e. all selected domains are seen in reset. On exit, async_local_rst_no returns to all ones in the next cycle.
    - If to_cnt == AckTimeout-1 first: set timeout_o, set timeout_mask_o = ack_s & mask_q, release outputs, go to DONE.
  - WAIT_REL
    - to_cnt restarts at 0.
    - Exit to DONE when (ack_s & mask_q) == mask_q.
    - On to_cnt == AckTimeout-1: set timeout_o, set timeout_mask_o = ~ack_s & mask_q, go to DONE.
  - DONE: done_o = 1 for exactly one cycle, then go to IDLE.
- Minimum ASSERT duration is MinAssertCycles cycles; the maximum is AckTimeout.
- Simultaneous success and timeout in the same cycle: success wins.
- Counters: width $clog2(AckTimeout+1). They saturate and never wrap.
- Reset mid-operation: everything returns to reset values immediately. Local requests release asynchronously to 1.
- Unselected channels never toggle.

Decomposition:
- Package hemaia_reset_pkg:
  - state enum (IDLE, ASSERT, WAIT_REL, DONE), 2-bit.
  - counter-width helper function.
- Sub-module hemaia_reset_ack_sync:
  - parameters Width and Stages.
  - async-reset-to-0 synchroniser vector.
  - instantiated once, for rst_ack_ni.

Test Plan (NumReset=4, MinAssertCycles=16, AckTimeout=64, AckSyncStages=2):
1. Mask 4'b0101 accepted at T; model acks follow requests after 3 cycles. Required: async_local_rst_no = 4'b1010 for exactly 16 cycles starting at T+1; done_o pulses once; timeout_o = 0; bits 1 and 3 never toggle.
2. Mask 4'b0000 accepted. Required: done_o at T+1, outputs stay 4'b1111, busy_o high for 1 cycle.
3. Channel 2 ack never goes low, mask 4'b0100. Required: ASSERT aborts after 64 cycles; timeout_o = 1; timeout_mask_o = 4'b0100; outputs return to 4'b1111; done_o pulses.
4. Channel 0 ack stuck low after release, mask 4'b0001. Required: WAIT_REL aborts after 64 cycles; timeout_mask_o = 4'b0001. A following good request clears timeout_o and completes normally.
5. Assert sync_ff_rst low in mid-ASSERT. Required: outputs go to 4'b1111 asynchronously; FSM in IDLE; req_ready_o = 1 after release; a new request is accepted.
6. Hold req_valid_i high with changing masks while busy. Required: only the first mask is latched; req_ready_o = 0 until after done_o.
